// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and limits for the bit-serial subtraction controller.
package sub_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/response bundle between an operand source and the serial subtractor.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );

endinterface

// File: rtl/serial_sub_ctrl_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit underflows.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: walks a single fs_bit cell over the operands LSB first,
// then publishes the difference and final borrow with a one-cycle done pulse.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_sub_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("serial_sub_ctrl: WIDTH must lie in 2..MAX_WIDTH");
        end
    endgenerate

    sub_state_t       state;
    sub_state_t       state_n;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_n;
    logic [CNT_W-1:0] cnt;
    logic             bq;
    logic             d;
    logic             bo;
    logic             last;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    fs_bit u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (bq),
        .d    (d),
        .bout (bo)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));
    // Accumulator with this cycle's difference bit entering at the MSB.
    assign sr_n = WIDTH'({d, sr} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            cnt      <= '0;
            bq       <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        bq  <= 1'b0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_n;
                    bq  <= bo;
                    cnt <= cnt + 1'b1;
                    // Results only move on completion so they stay stable while busy.
                    if (last) begin
                        diff_q   <= sr_n;
                        borrow_q <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule
